// File: rtl/switch_pkg.sv
// Shared definitions for the 4x4 switch: link layout, header fields and the
// output daemon state encoding.
package switch_pkg;

    localparam int NUM_PORTS      = 4;
    localparam int WORD_W         = 32;
    localparam int LINK_W         = 33;
    localparam int LINK_VALID_BIT = 32;

    localparam int DEST_MSB = 31;
    localparam int DEST_LSB = 24;
    localparam int LEN_MSB  = 23;
    localparam int LEN_LSB  = 8;
    localparam int SEQ_MSB  = 7;
    localparam int SEQ_LSB  = 0;

    typedef enum logic {
        OD_IDLE,
        OD_SEND
    } od_state_t;

    // Number of body words that follow a header word.
    function automatic logic [15:0] hdrLength(input logic [WORD_W-1:0] word);
        return word[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO. A write into a full FIFO is still accepted
// when a read happens on the same edge, since the read frees the slot.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doWrite;
    logic             w_doRead;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign dout      = r_mem[r_rdPtr];
    assign w_doRead  = rd_en && !empty;
    assign w_doWrite = wr_en && (!full || w_doRead);

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWrite) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_doRead) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_doWrite) - (AW+1)'(w_doRead);
        end
    end

endmodule

// File: rtl/output_daemon.sv
// Receive side of one switch output port: buffers the four input links,
// picks whole packets round-robin and streams them out with valid/ready.
module output_daemon
    import switch_pkg::*;
#(
    parameter int PORT_ID    = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINK_W-1:0] from_in_1,
    input  logic [LINK_W-1:0] from_in_2,
    input  logic [LINK_W-1:0] from_in_3,
    input  logic [LINK_W-1:0] from_in_4,
    output logic [WORD_W-1:0] output_word,
    output logic              output_valid,
    input  logic              out_ready,
    output logic [3:0]        overflow
);

    if (PORT_ID < 1 || PORT_ID > NUM_PORTS) begin : g_badPortId
        $error("output_daemon: PORT_ID must be 1..4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_badDepth
        $error("output_daemon: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic [LINK_W-1:0] w_link [NUM_PORTS];
    logic [WORD_W-1:0] w_dout [NUM_PORTS];
    logic [3:0]        w_full;
    logic [3:0]        w_empty;
    logic [3:0]        w_pop;
    logic [3:0]        w_drop;

    od_state_t         r_state;
    od_state_t         w_stateNext;
    logic [1:0]        r_rrPtr;
    logic [1:0]        r_grant;
    logic [15:0]       r_remaining;
    logic [WORD_W-1:0] r_word;
    logic              r_valid;
    logic [3:0]        r_overflow;

    logic              w_slotFree;
    logic              w_arbValid;
    logic [1:0]        w_arbGrant;
    logic [WORD_W-1:0] w_wordNext;
    logic              w_validNext;
    logic [15:0]       w_remainingNext;
    logic [1:0]        w_grantNext;
    logic [1:0]        w_rrNext;

    assign w_link[0] = from_in_1;
    assign w_link[1] = from_in_2;
    assign w_link[2] = from_in_3;
    assign w_link[3] = from_in_4;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
        sync_fifo #(
            .WIDTH (WORD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr_en (w_link[g][LINK_VALID_BIT]),
            .din   (w_link[g][WORD_W-1:0]),
            .rd_en (w_pop[g]),
            .dout  (w_dout[g]),
            .full  (w_full[g]),
            .empty (w_empty[g])
        );
        assign w_drop[g] = w_link[g][LINK_VALID_BIT] && w_full[g] && !w_pop[g];
    end

    assign w_slotFree   = !r_valid || out_ready;
    assign output_word  = r_word;
    assign output_valid = r_valid;
    assign overflow     = r_overflow;

    // Round-robin search: first non-empty FIFO starting at r_rrPtr, wrapping.
    always_comb begin
        w_arbValid = 1'b0;
        w_arbGrant = r_rrPtr;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (!w_empty[r_rrPtr + 2'(i)]) begin
                w_arbValid = 1'b1;
                w_arbGrant = r_rrPtr + 2'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OD_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: enter SEND on a header with a body, leave after the last body word.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            OD_IDLE: begin
                if (w_slotFree && w_arbValid && hdrLength(w_dout[w_arbGrant]) != 16'd0) begin
                    w_stateNext = OD_SEND;
                end
            end
            OD_SEND: begin
                if (w_slotFree && !w_empty[r_grant] && r_remaining == 16'd1) begin
                    w_stateNext = OD_IDLE;
                end
            end
            default: w_stateNext = OD_IDLE;
        endcase
    end

    // Outputs: FIFO pops and next values of the output slot and packet bookkeeping.
    always_comb begin
        w_pop           = '0;
        w_wordNext      = r_word;
        w_validNext     = r_valid;
        w_remainingNext = r_remaining;
        w_grantNext     = r_grant;
        w_rrNext        = r_rrPtr;
        case (r_state)
            OD_IDLE: begin
                if (w_slotFree) begin
                    if (w_arbValid) begin
                        w_pop[w_arbGrant] = 1'b1;
                        w_wordNext        = w_dout[w_arbGrant];
                        w_validNext       = 1'b1;
                        if (hdrLength(w_dout[w_arbGrant]) == 16'd0) begin
                            w_rrNext = w_arbGrant + 2'd1;
                        end else begin
                            w_remainingNext = hdrLength(w_dout[w_arbGrant]);
                            w_grantNext     = w_arbGrant;
                        end
                    end else begin
                        w_wordNext  = '0;
                        w_validNext = 1'b0;
                    end
                end
            end
            OD_SEND: begin
                if (w_slotFree) begin
                    if (!w_empty[r_grant]) begin
                        w_pop[r_grant]  = 1'b1;
                        w_wordNext      = w_dout[r_grant];
                        w_validNext     = 1'b1;
                        w_remainingNext = r_remaining - 16'd1;
                        if (r_remaining == 16'd1) begin
                            w_rrNext = r_grant + 2'd1;
                        end
                    end else begin
                        w_wordNext  = '0;
                        w_validNext = 1'b0;
                    end
                end
            end
            default: begin
                w_wordNext  = '0;
                w_validNext = 1'b0;
            end
        endcase
    end

    // Datapath registers and the sticky overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_remaining <= '0;
            r_grant     <= '0;
            r_rrPtr     <= '0;
            r_overflow  <= '0;
        end else begin
            r_word      <= w_wordNext;
            r_valid     <= w_validNext;
            r_remaining <= w_remainingNext;
            r_grant     <= w_grantNext;
            r_rrPtr     <= w_rrNext;
            r_overflow  <= r_overflow | w_drop;
        end
    end

endmodule
